// File: rtl/axi_ar_req_decoder_pkg.sv
// Shared types for the AR request decoder: FSM state encoding and AXI response codes.
package axi_ar_req_decoder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        OPERATIVE,
        ERROR_SAMPLE,
        ERROR_WAIT
    } ar_dec_state_t;

endpackage

// File: rtl/axi_ar_req_decoder_if.sv
// Incoming AR channel plus the one-hot valid/ready fan-out towards initiator ports.
interface axi_ar_req_decoder_if #(
    parameter int unsigned AXI_ADDR_W  = 32,
    parameter int unsigned AXI_ID_IN   = 16,
    parameter int unsigned AXI_USER_W  = 6,
    parameter int unsigned N_INIT_PORT = 4
);

    logic [AXI_ID_IN-1:0]   arid;
    logic [AXI_ADDR_W-1:0]  araddr;
    logic [7:0]             arlen;
    logic [AXI_USER_W-1:0]  aruser;
    logic                   arvalid;
    logic                   arready;
    logic [N_INIT_PORT-1:0] init_arvalid;
    logic [N_INIT_PORT-1:0] init_arready;

    modport master (
        output arid, araddr, arlen, aruser, arvalid, init_arready,
        input  arready, init_arvalid
    );

    modport slave (
        input  arid, araddr, arlen, aruser, arvalid, init_arready,
        output arready, init_arvalid
    );

endinterface

// File: rtl/axi_ar_req_decoder_region_match.sv
// Combinational address region matcher; lowest-index enabled region containing the address wins.
module axi_ar_req_decoder_region_match #(
    parameter int unsigned AXI_ADDR_W  = 32,
    parameter int unsigned N_INIT_PORT = 4
) (
    input  logic [AXI_ADDR_W-1:0]                  addr_i,
    input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] start_addr_i,
    input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] end_addr_i,
    input  logic [N_INIT_PORT-1:0]                 enable_region_i,
    output logic [N_INIT_PORT-1:0]                 match_o,
    output logic                                   hit_o
);

    always_comb begin
        match_o = '0;
        hit_o   = 1'b0;
        for (int unsigned i = 0; i < N_INIT_PORT; i++) begin
            if (!hit_o && enable_region_i[i] &&
                (addr_i >= start_addr_i[i]) && (addr_i <= end_addr_i[i])) begin
                match_o[i] = 1'b1;
                hit_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_ar_req_decoder.sv
// AR front end of one target port: routes decoded ARs to initiator ports and
// absorbs unmapped ones into a DECERR request towards the R-channel allocator.
module axi_ar_req_decoder
    import axi_ar_req_decoder_pkg::*;
#(
    parameter int unsigned AXI_ADDR_W  = 32,
    parameter int unsigned AXI_ID_IN   = 16,
    parameter int unsigned AXI_USER_W  = 6,
    parameter int unsigned N_INIT_PORT = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    axi_ar_req_decoder_if.slave                    ar,
    input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] start_addr_i,
    input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] end_addr_i,
    input  logic [N_INIT_PORT-1:0]                 enable_region_i,
    output logic                                   incr_req_o,
    input  logic                                   full_counter_i,
    output logic                                   error_req_o,
    input  logic                                   error_gnt_i,
    output logic [7:0]                             error_len_o,
    output logic [AXI_USER_W-1:0]                  error_user_o,
    output logic [AXI_ID_IN-1:0]                   error_id_o,
    output logic                                   sample_ardata_info_o
);

    ar_dec_state_t          state_q, state_d;
    logic                   error_req_q, error_req_d;
    logic                   sample_q, sample_d;
    logic [7:0]             error_len_q, error_len_d;
    logic [AXI_USER_W-1:0]  error_user_q, error_user_d;
    logic [AXI_ID_IN-1:0]   error_id_q, error_id_d;

    logic [N_INIT_PORT-1:0] match;
    logic                   hit;
    logic                   route_ready;

    axi_ar_req_decoder_region_match #(
        .AXI_ADDR_W  (AXI_ADDR_W),
        .N_INIT_PORT (N_INIT_PORT)
    ) u_region_match (
        .addr_i          (ar.araddr),
        .start_addr_i    (start_addr_i),
        .end_addr_i      (end_addr_i),
        .enable_region_i (enable_region_i),
        .match_o         (match),
        .hit_o           (hit)
    );

    assign route_ready = |(ar.init_arready & match);

    always_comb begin
        state_d         = state_q;
        error_req_d     = error_req_q;
        sample_d        = 1'b0;
        error_len_d     = error_len_q;
        error_user_d    = error_user_q;
        error_id_d      = error_id_q;
        ar.arready      = 1'b0;
        ar.init_arvalid = '0;
        incr_req_o      = 1'b0;

        unique case (state_q)
            OPERATIVE: begin
                if (ar.arvalid) begin
                    if (hit) begin
                        // Saturated allocator holds the request back entirely.
                        if (!full_counter_i) begin
                            ar.init_arvalid = match;
                            ar.arready      = route_ready;
                            incr_req_o      = route_ready;
                        end
                    end else begin
                        ar.arready   = 1'b1;
                        error_len_d  = ar.arlen;
                        error_user_d = ar.aruser;
                        error_id_d   = ar.arid;
                        error_req_d  = 1'b1;
                        sample_d     = 1'b1;
                        state_d      = ERROR_SAMPLE;
                    end
                end
            end
            ERROR_SAMPLE, ERROR_WAIT: begin
                if (error_gnt_i) begin
                    error_req_d = 1'b0;
                    state_d     = OPERATIVE;
                end else begin
                    state_d     = ERROR_WAIT;
                end
            end
            default: begin
                error_req_d = 1'b0;
                state_d     = OPERATIVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= OPERATIVE;
            error_req_q  <= 1'b0;
            sample_q     <= 1'b0;
            error_len_q  <= '0;
            error_user_q <= '0;
            error_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            error_req_q  <= error_req_d;
            sample_q     <= sample_d;
            error_len_q  <= error_len_d;
            error_user_q <= error_user_d;
            error_id_q   <= error_id_d;
        end
    end

    assign error_req_o          = error_req_q;
    assign sample_ardata_info_o = sample_q;
    assign error_len_o          = error_len_q;
    assign error_user_o         = error_user_q;
    assign error_id_o           = error_id_q;

endmodule

// File: tb/tb_axi_ar_req_decoder.sv
// Directed bench for axi_ar_req_decoder with a transaction-level reference model checked every cycle.
module tb_axi_ar_req_decoder;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0][31:0]   start_addr, end_addr;
    logic [3:0]         enable_region;
    logic               incr_req, full_counter, error_req, error_gnt, sample_info;
    logic [7:0]         error_len;
    logic [5:0]         error_user;
    logic [15:0]        error_id;

    int errors = 0;
    int checks = 0;

    axi_ar_req_decoder_if #(
        .AXI_ADDR_W(32), .AXI_ID_IN(16), .AXI_USER_W(6), .N_INIT_PORT(4)
    ) ar_if ();

    axi_ar_req_decoder #(
        .AXI_ADDR_W(32), .AXI_ID_IN(16), .AXI_USER_W(6), .N_INIT_PORT(4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ar                   (ar_if.slave),
        .start_addr_i         (start_addr),
        .end_addr_i           (end_addr),
        .enable_region_i      (enable_region),
        .incr_req_o           (incr_req),
        .full_counter_i       (full_counter),
        .error_req_o          (error_req),
        .error_gnt_i          (error_gnt),
        .error_len_o          (error_len),
        .error_user_o         (error_user),
        .error_id_o           (error_id),
        .sample_ardata_info_o (sample_info)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending decode-error transaction with its captured fields.
    logic        m_busy = 1'b0;
    logic        m_first = 1'b0;
    logic [15:0] m_id = '0;
    logic [7:0]  m_len = '0;
    logic [5:0]  m_user = '0;

    always @(negedge clk) begin : model_cmp
        int         sel;
        logic [3:0] e_vo;
        logic       e_rdy, e_incr;
        sel = -1;
        for (int i = 0; i < 4; i++)
            if (sel < 0 && enable_region[i] &&
                ar_if.araddr >= start_addr[i] && ar_if.araddr <= end_addr[i])
                sel = i;
        e_vo = 4'b0000; e_rdy = 1'b0; e_incr = 1'b0;
        if (!m_busy && ar_if.arvalid) begin
            if (sel < 0) e_rdy = 1'b1;
            else if (!full_counter) begin
                e_vo   = 4'b0001 << sel;
                e_rdy  = ar_if.init_arready[sel];
                e_incr = e_rdy;
            end
        end
        chk("m_arvalid_o", {28'd0, ar_if.init_arvalid}, {28'd0, e_vo});
        chk("m_arready_o", {31'd0, ar_if.arready}, {31'd0, e_rdy});
        chk("m_incr_req", {31'd0, incr_req}, {31'd0, e_incr});
        chk("m_error_req", {31'd0, error_req}, {31'd0, m_busy});
        chk("m_sample", {31'd0, sample_info}, {31'd0, m_busy & m_first});
        chk("m_error_id", {16'd0, error_id}, {16'd0, m_id});
        chk("m_error_len", {24'd0, error_len}, {24'd0, m_len});
        chk("m_error_user", {26'd0, error_user}, {26'd0, m_user});
        if (rst) begin
            m_busy = 1'b0; m_first = 1'b0; m_id = '0; m_len = '0; m_user = '0;
        end else if (m_busy) begin
            m_first = 1'b0;
            if (error_gnt) m_busy = 1'b0;
        end else if (ar_if.arvalid && sel < 0) begin
            m_busy = 1'b1; m_first = 1'b1;
            m_id = ar_if.arid; m_len = ar_if.arlen; m_user = ar_if.aruser;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ar(input logic [31:0] addr, input logic [15:0] id,
                            input logic [7:0] len, input logic [5:0] user);
        ar_if.arvalid = 1'b1;
        ar_if.araddr  = addr;
        ar_if.arid    = id;
        ar_if.arlen   = len;
        ar_if.aruser  = user;
    endtask

    task automatic idle();
        ar_if.arvalid      = 1'b0;
        ar_if.araddr       = '0;
        ar_if.init_arready = '0;
    endtask

    logic [31:0] tbl_addr [8];
    logic [3:0]  tbl_en   [8];
    logic [3:0]  tbl_exp  [8];

    initial begin
        rst = 1'b1; full_counter = 1'b0; error_gnt = 1'b0;
        ar_if.arid = '0; ar_if.arlen = '0; ar_if.aruser = '0;
        idle();
        start_addr[0] = 32'h0000_0000; end_addr[0] = 32'h0FFF_FFFF;
        start_addr[1] = 32'h1000_0000; end_addr[1] = 32'h1FFF_FFFF;
        start_addr[2] = 32'h1000_0000; end_addr[2] = 32'h1000_FFFF;
        start_addr[3] = 32'h2000_0000; end_addr[3] = 32'h2FFF_FFFF;
        enable_region = 4'b0011;

        tick(); tick();
        chk("rst_error_req", {31'd0, error_req}, 32'd0);
        chk("rst_error_id", {16'd0, error_id}, 32'd0);
        chk("rst_arready", {31'd0, ar_if.arready}, 32'd0);
        chk("rst_arvalid_o", {28'd0, ar_if.init_arvalid}, 32'd0);
        rst = 1'b0;

        // Routed AR to region 1, accepted in the same cycle
        drive_ar(32'h1000_0040, 16'h0001, 8'd0, 6'd0);
        ar_if.init_arready = 4'b0010;
        #1;
        chk("route_valid", {28'd0, ar_if.init_arvalid}, 32'h2);
        chk("route_ready", {31'd0, ar_if.arready}, 32'd1);
        chk("route_incr", {31'd0, incr_req}, 32'd1);
        tick(); idle();

        // Overlap with region 2: lowest index wins
        enable_region = 4'b0111;
        drive_ar(32'h1000_0100, 16'h0002, 8'd1, 6'd0);
        #1;
        chk("overlap_valid", {28'd0, ar_if.init_arvalid}, 32'h2);
        chk("overlap_noready", {31'd0, ar_if.arready}, 32'd0);
        tick();
        ar_if.init_arready = 4'b0010;
        #1;
        chk("overlap_hs", {31'd0, ar_if.arready}, 32'd1);
        tick(); idle();

        // Unmapped AR: decode-error path, grant at T+5
        drive_ar(32'hF000_0000, 16'h001A, 8'd7, 6'd5);
        #1;
        chk("err_accept", {31'd0, ar_if.arready}, 32'd1);
        chk("err_novalid", {28'd0, ar_if.init_arvalid}, 32'd0);
        tick();
        drive_ar(32'h0000_0010, 16'h0002, 8'd0, 6'd0);
        ar_if.init_arready = 4'b0001;
        #1;
        chk("err_sample", {31'd0, sample_info}, 32'd1);
        chk("err_req_t1", {31'd0, error_req}, 32'd1);
        chk("err_len", {24'd0, error_len}, 32'd7);
        chk("err_id", {16'd0, error_id}, 32'h1A);
        chk("err_user", {26'd0, error_user}, 32'd5);
        chk("err_blocked_t1", {31'd0, ar_if.arready}, 32'd0);
        for (int k = 2; k <= 4; k++) begin
            tick(); #1;
            chk("err_hold", {31'd0, error_req}, 32'd1);
            chk("err_blocked", {31'd0, ar_if.arready}, 32'd0);
            chk("err_nosample", {31'd0, sample_info}, 32'd0);
        end
        tick();
        error_gnt = 1'b1;
        #1;
        chk("err_req_grant", {31'd0, error_req}, 32'd1);
        chk("err_blocked_t5", {31'd0, ar_if.arready}, 32'd0);
        tick();
        error_gnt = 1'b0;
        #1;
        chk("err_req_cleared", {31'd0, error_req}, 32'd0);
        chk("second_ar_accept", {31'd0, ar_if.arready}, 32'd1);
        chk("second_ar_valid", {28'd0, ar_if.init_arvalid}, 32'h1);
        tick(); idle();

        // Full counter stall for 10 cycles, then release
        full_counter = 1'b1;
        drive_ar(32'h0500_0000, 16'h0003, 8'd2, 6'd1);
        ar_if.init_arready = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("stall_valid", {28'd0, ar_if.init_arvalid}, 32'd0);
            chk("stall_ready", {31'd0, ar_if.arready}, 32'd0);
            tick();
        end
        full_counter = 1'b0;
        #1;
        chk("release_valid", {28'd0, ar_if.init_arvalid}, 32'h1);
        chk("release_incr", {31'd0, incr_req}, 32'd1);
        tick(); idle();
        #1;
        chk("release_incr_once", {31'd0, incr_req}, 32'd0);

        // Grant while operative is ignored
        error_gnt = 1'b1;
        tick();
        error_gnt = 1'b0;
        #1;
        chk("stray_gnt", {31'd0, error_req}, 32'd0);

        // Disabled region 1 -> error; grant in sample cycle
        enable_region = 4'b0001;
        drive_ar(32'h1000_0000, 16'h002B, 8'd3, 6'd1);
        #1;
        chk("dis_accept", {31'd0, ar_if.arready}, 32'd1);
        tick(); idle();
        error_gnt = 1'b1;
        #1;
        chk("dis_req", {31'd0, error_req}, 32'd1);
        chk("dis_sample", {31'd0, sample_info}, 32'd1);
        tick();
        error_gnt = 1'b0;
        drive_ar(32'h0000_0100, 16'h0004, 8'd0, 6'd0);
        ar_if.init_arready = 4'b0001;
        #1;
        chk("dis_req_clr", {31'd0, error_req}, 32'd0);
        chk("dis_next_accept", {31'd0, ar_if.arready}, 32'd1);
        tick(); idle();

        // Reset while waiting for grant
        drive_ar(32'hF000_0000, 16'h0033, 8'd2, 6'd2);
        #1;
        chk("rw_accept", {31'd0, ar_if.arready}, 32'd1);
        tick(); idle();
        tick();
        rst = 1'b1;
        #1;
        chk("rw_req_wait", {31'd0, error_req}, 32'd1);
        tick();
        rst = 1'b0;
        drive_ar(32'h0000_0200, 16'h0005, 8'd0, 6'd0);
        ar_if.init_arready = 4'b0001;
        #1;
        chk("rw_req_clr", {31'd0, error_req}, 32'd0);
        chk("rw_id_clr", {16'd0, error_id}, 32'd0);
        chk("rw_len_clr", {24'd0, error_len}, 32'd0);
        chk("rw_accept_new", {31'd0, ar_if.arready}, 32'd1);
        tick(); idle();

        // Inclusive region boundaries
        tbl_addr[0] = 32'h0FFF_FFFF; tbl_en[0] = 4'b1111; tbl_exp[0] = 4'b0001;
        tbl_addr[1] = 32'h1000_0000; tbl_en[1] = 4'b1111; tbl_exp[1] = 4'b0010;
        tbl_addr[2] = 32'h1FFF_FFFF; tbl_en[2] = 4'b1111; tbl_exp[2] = 4'b0010;
        tbl_addr[3] = 32'h2000_0000; tbl_en[3] = 4'b1111; tbl_exp[3] = 4'b1000;
        tbl_addr[4] = 32'h2FFF_FFFF; tbl_en[4] = 4'b1111; tbl_exp[4] = 4'b1000;
        tbl_addr[5] = 32'h3000_0000; tbl_en[5] = 4'b1111; tbl_exp[5] = 4'b0000;
        tbl_addr[6] = 32'h1000_FFFF; tbl_en[6] = 4'b0100; tbl_exp[6] = 4'b0100;
        tbl_addr[7] = 32'h1001_0000; tbl_en[7] = 4'b0100; tbl_exp[7] = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            enable_region = tbl_en[k];
            drive_ar(tbl_addr[k], 16'h0100 + 16'(k), 8'(k), 6'(k));
            ar_if.init_arready = 4'b1111;
            #1;
            chk("bound_valid", {28'd0, ar_if.init_arvalid}, {28'd0, tbl_exp[k]});
            chk("bound_ready", {31'd0, ar_if.arready}, 32'd1);
            tick(); idle();
            if (tbl_exp[k] == 4'b0000) begin
                error_gnt = 1'b1;
                tick();
                error_gnt = 1'b0;
            end
        end

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_ar_req_decoder.md
# axi_AR_req_decoder

Read-address front end of one target port of the AXI 4 interconnect. Decodes each incoming AR against per-initiator address regions and steers it to the single matching initiator port. Unmapped addresses are absorbed locally and turned into a decode-error request towards the same target port's R-channel allocator, which then generates the DECERR data beats. Also drives the outstanding-read increment for that allocator and stalls on its full flag.

## Interface
- AXI_ADDR_W, 32, address width
- AXI_ID_IN, 16, incoming ID width
- AXI_USER_W, 6, user width
- N_INIT_PORT, 4, number of initiator ports (regions)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- arid_i / araddr_i / arlen_i / aruser_i  in  AXI_ID_IN / AXI_ADDR_W / 8 / AXI_USER_W  incoming AR payload
- arvalid_i  in  1;  arready_o  out  1  incoming AR handshake
- arvalid_o  out  N_INIT_PORT  one-hot request to initiator ports (payload forwarded unregistered by parent)
- arready_i  in  N_INIT_PORT  initiator-port ready
- start_addr_i / end_addr_i  in  N_INIT_PORT×AXI_ADDR_W  inclusive region bounds, static while arvalid_i=1
- enable_region_i  in  N_INIT_PORT  region enable
- incr_req_o  out  1  one accepted routed AR
- full_counter_i  in  1  allocator outstanding counter saturated
- error_req_o  out  1;  error_gnt_i  in  1  error-response request/grant
- error_len_o / error_user_o / error_id_o  out  8 / AXI_USER_W / AXI_ID_IN  registered info of the failing AR
- sample_ardata_info_o  out  1  one-cycle strobe: error info valid, allocator samples it

## Operation
- Match: region i hits when enable_region_i[i] and start_addr_i[i] ≤ araddr_i ≤ end_addr_i (unsigned, full width). Several hits: lowest index wins. hit = any match.
- States: OPERATIVE, ERROR_SAMPLE, ERROR_WAIT. Reset → OPERATIVE.
- OPERATIVE, arvalid_i=1, hit, full_counter_i=0: arvalid_o[sel]=1, arready_o=arready_i[sel], incr_req_o=arready_i[sel]. Stay.
- OPERATIVE, arvalid_i=1, hit, full_counter_i=1: arvalid_o=0, arready_o=0, incr_req_o=0 (stall).
- OPERATIVE, arvalid_i=1, no hit: arready_o=1; register arid_i/arlen_i/aruser_i into error_*_o; → ERROR_SAMPLE. incr_req_o=0, arvalid_o=0.
- ERROR_SAMPLE: error_req_o=1, sample_ardata_info_o=1, arready_o=0; → ERROR_WAIT (→ OPERATIVE if error_gnt_i=1 same cycle).
- ERROR_WAIT: error_req_o=1, arready_o=0, arvalid_o=0; error_gnt_i=1 → OPERATIVE, else stay.
- error_*_o change only on error acceptance; stable throughout ERROR_SAMPLE/ERROR_WAIT (allocator reads error_len live during bursts).
- Error path never asserts incr_req_o; allocator itself drains outstanding reads before answering.

## Timing
- Reset values: arready_o=0 when arvalid_i=0; arvalid_o=0, incr_req_o=0, error_req_o=0, sample_ardata_info_o=0, error_len_o/user/id=0, state OPERATIVE.
- Routed AR: zero-cycle combinational path arvalid_i→arvalid_o, arready_i→arready_o.
- Error AR accepted at cycle T: error_req_o=1 and sample strobe at T+1; error_req_o held until the cycle error_gnt_i=1 inclusive; low next cycle. Earliest new AR acceptance: cycle after grant.
- error_gnt_i outside ERROR_SAMPLE/ERROR_WAIT: ignored.
- full_counter_i rising while stalled: stays stalled; arvalid_o never drops after assertion except by handshake (full only rises via incr).
- rst=1 mid-error: state → OPERATIVE, error_req_o low next cycle, registers cleared.

## Structure
- State enum ar_dec_state_t {OPERATIVE, ERROR_SAMPLE, ERROR_WAIT} in axi_pkg beside RESP_DECERR.
- Sub-module axi_AR_region_match: combinational, produces one-hot match_o and hit_o from address and region arrays (priority lowest index).
- Top holds FSM, error registers, handshake muxing.

## Test plan
- Regions 0:0x0000_0000–0x0FFF_FFFF, 1:0x1000_0000–0x1FFF_FFFF, all enabled; AR addr 0x1000_0040, arready_i=4'b0010 → arvalid_o=4'b0010, arready_o=1, incr_req_o=1 same cycle.
- Overlap: region 2 = 0x1000_0000–0x1000_FFFF also enabled; addr 0x1000_0100 → arvalid_o=4'b0010 (lowest wins).
- Addr 0xF000_0000, id 0x1A, len 7, user 5 → arready_o=1 at T; T+1 sample=1, error_req=1, error_len_o=7, error_id_o=0x1A; grant at T+5 → error_req_o=0 at T+6; second AR blocked T+1..T+5.
- full_counter_i=1 with legal AR → arvalid_o=0, arready_o=0 for 10 cycles; deassert full → forwarded next cycle, incr_req_o=1 once.
- Region 1 disabled, addr 0x1000_0000 → error path; error_gnt_i in ERROR_SAMPLE → OPERATIVE next cycle.
- rst=1 in ERROR_WAIT → next cycle error_req_o=0, error_id_o=0, new legal AR accepted.
